// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants and helpers for the register write arbiter
package reg_arb_pkg;

    localparam int NUM_REQ_MAX = 16;
    localparam int CNT_W_DEF   = 16;

    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/downstream bundle of the register write arbiter
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int CNT_W   = CNT_W_DEF
);
    localparam int IDW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wr_stall;
    logic                     reg_load;
    logic [WIDTH-1:0]         reg_d;
    logic [IDW-1:0]           grant_id;
    logic [CNT_W-1:0]         wr_count;

    modport master (
        output req_valid, req_data, req_lock, wr_stall,
        input  req_ready, reg_load, reg_d, grant_id, wr_count
    );

    modport slave (
        input  req_valid, req_data, req_lock, wr_stall,
        output req_ready, reg_load, reg_d, grant_id, wr_count
    );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any_valid && req[idx]) begin
                winner    = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter feeding one staged write into a shared register
// Optional ownership locking is compiled in with REG_ARB_LOCK_EN.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_write_arbiter_if.slave   bus
);

    localparam int IDW = idx_w(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t             stage;
    logic [IDW-1:0]     rr_ptr;
    logic [CNT_W-1:0]   wr_count;
    logic [NUM_REQ-1:0] cand;
    logic [IDW-1:0]     winner;
    logic               any_valid;
    logic               accept_ok;
    logic               accept;
    logic               load;
    logic [IDW-1:0]     ptr_next;

`ifdef REG_ARB_LOCK_EN
    logic               lock_active;
    logic [IDW-1:0]     lock_owner;

    // A held lock hides every other requester, even while the owner is idle.
    assign cand = lock_active ? (bus.req_valid & (NUM_REQ'(1) << lock_owner)) : bus.req_valid;
`else
    assign cand = bus.req_valid;
`endif

    rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .req       (cand),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign accept_ok = !stage.valid || !bus.wr_stall;
    assign accept    = rst_n && any_valid && accept_ok;
    assign load      = rst_n && stage.valid && !bus.wr_stall;
    assign ptr_next  = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    assign bus.reg_load = load;
    assign bus.reg_d    = stage.data;
    assign bus.grant_id = stage.id;
    assign bus.wr_count = wr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage    <= '0;
            rr_ptr   <= '0;
            wr_count <= '0;
`ifdef REG_ARB_LOCK_EN
            lock_active <= 1'b0;
            lock_owner  <= '0;
`endif
        end else begin
            // Draining and refilling in the same cycle keeps one write per clock.
            if (accept) begin
                stage.valid <= 1'b1;
                stage.id    <= winner;
                stage.data  <= bus.req_data[winner*WIDTH +: WIDTH];
                rr_ptr      <= ptr_next;
`ifdef REG_ARB_LOCK_EN
                lock_active <= bus.req_lock[winner];
                lock_owner  <= winner;
`endif
            end else if (load) begin
                stage.valid <= 1'b0;
            end
            if (load) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

`ifndef REG_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int CW  = 4;
    localparam int IDW = idx_w(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) bus();
    reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model state, kept as plain integers
    bit          m_sv;
    logic [W-1:0] m_sd;
    int          m_sid, m_ptr, m_cnt, m_lo;
    bit          m_lk;

    logic [N-1:0]   e_ready;
    bit             e_load;
    logic [W-1:0]   e_d;
    logic [IDW-1:0] e_gid;
    logic [CW-1:0]  e_cnt;
    int             e_win;

    task automatic model_eval();
        int win;
        bit aok;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && bus.req_valid[j] && (!m_lk || j == m_lo)) win = j;
        end
        aok     = !m_sv || !bus.wr_stall;
        e_ready = '0;
        e_win   = -1;
        if (rst_n && aok && win >= 0) begin
            e_ready[win] = 1'b1;
            e_win = win;
        end
        e_load = rst_n && m_sv && !bus.wr_stall;
        e_d    = m_sd;
        e_gid  = IDW'(m_sid);
        e_cnt  = CW'(m_cnt);
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_sv = 0; m_sd = '0; m_sid = 0; m_ptr = 0; m_cnt = 0; m_lk = 0; m_lo = 0;
        end else begin
            if (e_load) m_cnt = (m_cnt + 1) % (1 << CW);
            if (e_win >= 0) begin
                m_sv  = 1;
                m_sd  = bus.req_data[e_win*W +: W];
                m_sid = e_win;
                m_ptr = (e_win + 1) % N;
`ifdef REG_ARB_LOCK_EN
                m_lk  = bus.req_lock[e_win];
                m_lo  = e_win;
`endif
            end else if (e_load) begin
                m_sv = 0;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_lock = '0; bus.wr_stall = 1'b0;
        half(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1; bus.req_lock = '0; bus.wr_stall = 1'b0;
        rand_data();
        half();
        checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.reg_load !== 1'b0) begin fails++; $display("FAIL reset_load got %b exp 0", bus.reg_load); end
        step(); half();
        checks++; if ({bus.reg_d, bus.grant_id, bus.wr_count} !== '0)
            begin fails++; $display("FAIL reset_state got d=%h id=%0d cnt=%0d exp 0", bus.reg_d, bus.grant_id, bus.wr_count); end
        step();
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: W] = 32'hDEADBEEF;
        half();
        checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b exp 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        half();
        checks++; if ({bus.reg_load, bus.reg_d, bus.grant_id} !== {1'b1, 32'hDEADBEEF, IDW'(0)})
            begin fails++; $display("FAIL single_load got load=%b d=%h id=%0d exp 1 deadbeef 0", bus.reg_load, bus.reg_d, bus.grant_id); end
        step(); half();
        checks++; if (bus.wr_count !== CW'(1)) begin fails++; $display("FAIL single_count got %0d exp 1", bus.wr_count); end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'b1111;
            rand_data();
            half();
            checks++; if (bus.req_ready !== 4'(1 << (c % 4)))
                begin fails++; $display("FAIL rr_order cyc%0d got %b exp %b", c, bus.req_ready, 4'(1 << (c % 4))); end
            if (c > 0) begin
                checks++; if ({bus.reg_load, bus.reg_d, bus.grant_id} !== {1'b1, e_d, e_gid})
                    begin fails++; $display("FAIL rr_load cyc%0d got %b %h %0d exp 1 %h %0d", c, bus.reg_load, bus.reg_d, bus.grant_id, e_d, e_gid); end
            end
            step();
        end
        bus.req_valid = '0;
        half(); step(); half();
        checks++; if (bus.wr_count !== CW'(8)) begin fails++; $display("FAIL rr_count got %0d exp 8", bus.wr_count); end
        step();
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        bus.req_valid = 4'b0001;
        rand_data();
        held = bus.req_data[0 +: W];
        half(); step();
        bus.wr_stall = 1'b1;
        bus.req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            half();
            checks++; if ({bus.req_ready, bus.reg_load, bus.reg_d} !== {4'b0000, 1'b0, held})
                begin fails++; $display("FAIL stall_hold cyc%0d got %b %b %h exp 0000 0 %h", c, bus.req_ready, bus.reg_load, bus.reg_d, held); end
            step();
        end
        bus.wr_stall = 1'b0;
        half();
        checks++; if ({bus.req_ready, bus.reg_load, bus.reg_d} !== {4'b0010, 1'b1, held})
            begin fails++; $display("FAIL stall_release got %b %b %h exp 0010 1 %h", bus.req_ready, bus.reg_load, bus.reg_d, held); end
        held = bus.req_data[1*W +: W];
        step(); half();
        checks++; if ({bus.req_ready, bus.reg_load, bus.reg_d, bus.grant_id} !== {4'b0100, 1'b1, held, IDW'(1)})
            begin fails++; $display("FAIL stall_next got %b %b %h %0d exp 0100 1 %h 1", bus.req_ready, bus.reg_load, bus.reg_d, bus.grant_id, held); end
        step();
        bus.req_valid = '0;
        half(); step();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 4'b1000;
        rand_data();
        half(); step();
        bus.req_valid = '0;
        rst_n = 1'b0;
        half();
        checks++; if (bus.reg_load !== 1'b0) begin fails++; $display("FAIL midrst_load got %b exp 0", bus.reg_load); end
        step();
        rst_n = 1'b1;
        half();
        checks++; if ({bus.reg_load, bus.wr_count} !== {1'b0, CW'(0)})
            begin fails++; $display("FAIL midrst_after got load=%b cnt=%0d exp 0 0", bus.reg_load, bus.wr_count); end
        step();
        bus.req_valid = 4'b1111;
        half();
        checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ptr got %b exp 0001", bus.req_ready); end
        step();
        bus.req_valid = '0;
        half(); step();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 17; c++) begin
            bus.req_valid = 4'($urandom_range(1, 15));
            rand_data();
            half(); step();
        end
        bus.req_valid = '0;
        half(); step(); half();
        checks++; if (bus.wr_count !== CW'(1)) begin fails++; $display("FAIL wrap_count got %0d exp 1", bus.wr_count); end
        checks++; if (bus.wr_count !== e_cnt) begin fails++; $display("FAIL wrap_model got %0d exp %0d", bus.wr_count, e_cnt); end
        step();
    endtask

    task automatic test_lock();
        int exp_seq [6];
`ifdef REG_ARB_LOCK_EN
        exp_seq = '{2, 2, 2, 0, 1, 2};
`else
        exp_seq = '{2, 0, 1, 2, 0, 1};
`endif
        do_reset();
        bus.req_valid = 4'b0010;
        rand_data();
        half(); step();
        for (int c = 0; c < 6; c++) begin
            bus.req_valid = 4'b0111;
            bus.req_lock  = (c < 2) ? 4'b0100 : 4'b0000;
            rand_data();
            half();
            checks++; if (bus.req_ready !== 4'(1 << exp_seq[c]))
                begin fails++; $display("FAIL lock_order cyc%0d got %b exp %b", c, bus.req_ready, 4'(1 << exp_seq[c])); end
            step();
        end
        bus.req_valid = '0; bus.req_lock = '0;
        half(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            bus.req_valid = 4'($urandom);
            bus.req_lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            bus.wr_stall  = ($urandom_range(0, 3) == 0);
            rand_data();
            half();
            checks++; if ({bus.req_ready, bus.reg_load, bus.reg_d, bus.grant_id, bus.wr_count} !== {e_ready, e_load, e_d, e_gid, e_cnt})
                begin fails++; $display("FAIL random cyc%0d got rdy=%b ld=%b d=%h id=%0d cnt=%0d exp rdy=%b ld=%b d=%h id=%0d cnt=%0d",
                    c, bus.req_ready, bus.reg_load, bus.reg_d, bus.grant_id, bus.wr_count, e_ready, e_load, e_d, e_gid, e_cnt); end
            step();
        end
        rst_n = 1'b1;
        bus.req_valid = '0; bus.req_lock = '0; bus.wr_stall = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        bus.wr_stall  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
